// File: rtl/vec_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : vec_mem_seq
// Description : Strided vector load/store sequencer (0-4 x 16-bit elements)
//               between the CVP14 datapath and a single-port static RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_mem_seq #(
    parameter int RD_LAT = 1
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_base,
    input  logic [15:0] req_stride,
    input  logic [2:0]  req_cnt,
    input  logic [15:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic [1:0]  rdata_idx,
    output logic        done,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic [15:0] DataOut,
    input  logic [15:0] DataIn
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WDAT     = 3'd3,
        S_WR_ISSUE = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] c_lat_last = 3'(RD_LAT - 1);
    localparam logic [2:0] c_lat      = 3'(RD_LAT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  r_wcnt;
    logic [1:0]  r_idx;
    logic [15:0] r_a;
    logic [15:0] r_stride;
    logic [15:0] r_addr;
    logic [15:0] r_dataout;
    logic [15:0] r_rdata;
    logic [1:0]  r_rdata_idx;
    logic        r_rd;
    logic        r_wr;
    logic        r_rdata_valid;

    logic [2:0]  w_cnt_in;
    logic [15:0] w_a_inc;
    logic        w_accept;
    logic        w_last;
    logic        w_capture;
    logic        w_wr_go;
    logic        w_advance;

    assign w_cnt_in = (req_cnt > 3'd4) ? 3'd4 : req_cnt;
    assign w_a_inc  = r_a + r_stride;
    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_last   = ({1'b0, r_idx} == (r_cnt - 3'd1));

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The last load element gets one extra RD_WAIT cycle so its rdata_valid
    // precedes the done pulse instead of coinciding with it.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_wr_go     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_cnt_in == 3'd0) begin
                        w_state_nxt = S_DONE;
                    end else if (req_wr) begin
                        w_state_nxt = S_WDAT;
                    end else begin
                        w_state_nxt = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (r_wcnt == c_lat_last) begin
                    w_capture = 1'b1;
                    if (!w_last) begin
                        w_advance   = 1'b1;
                        w_state_nxt = S_RD_ISSUE;
                    end
                end else if (r_wcnt == c_lat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WDAT: begin
                if (wdata_valid) begin
                    w_wr_go     = 1'b1;
                    w_state_nxt = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_WDAT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_cnt         <= 3'd0;
            r_wcnt        <= 3'd0;
            r_idx         <= 2'd0;
            r_a           <= 16'd0;
            r_stride      <= 16'd0;
            r_addr        <= 16'd0;
            r_dataout     <= 16'd0;
            r_rdata       <= 16'd0;
            r_rdata_idx   <= 2'd0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rd          <= (w_state_nxt == S_RD_ISSUE);
            r_wr          <= w_wr_go;
            r_rdata_valid <= w_capture;

            if (w_accept) begin
                r_cnt    <= w_cnt_in;
                r_stride <= req_stride;
                r_a      <= req_base;
                r_idx    <= 2'd0;
            end else if (w_advance) begin
                r_a   <= w_a_inc;
                r_idx <= r_idx + 2'd1;
            end

            // Addr only moves when a strobe is about to be issued.
            if (w_state_nxt == S_RD_ISSUE) begin
                r_addr <= w_accept ? req_base : w_a_inc;
            end else if (w_wr_go) begin
                r_addr <= r_a;
            end

            if (w_wr_go) begin
                r_dataout <= wdata;
            end

            if (r_state == S_RD_ISSUE) begin
                r_wcnt <= 3'd0;
            end else if (r_state == S_RD_WAIT) begin
                r_wcnt <= r_wcnt + 3'd1;
            end

            if (w_capture) begin
                r_rdata     <= DataIn;
                r_rdata_idx <= r_idx;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign wdata_ready = (r_state == S_WDAT);
    assign done        = (r_state == S_DONE);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign rdata_idx   = r_rdata_idx;
    assign Addr        = r_addr;
    assign RD          = r_rd;
    assign WR          = r_wr;
    assign DataOut     = r_dataout;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_mem_seq
// Description : Scoreboard bench for vec_mem_seq with RD_LAT = 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mem_seq;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  idx;
    } ev_t;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic        req_valid1, req_valid3, req_wr, wdata_valid;
    logic [15:0] req_base, req_stride, wdata;
    logic [2:0]  req_cnt;

    logic        req_ready1, wdata_ready1, rdata_valid1, done1, RD1, WR1;
    logic [15:0] rdata1, Addr1, DataOut1, DataIn1;
    logic [1:0]  rdata_idx1;
    logic        req_ready3, wdata_ready3, rdata_valid3, done3, RD3, WR3;
    logic [15:0] rdata3, Addr3, DataOut3, DataIn3;
    logic [1:0]  rdata_idx3;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    ev_t q_rd1[$], q_rv1[$], q_wr1[$], q_dn1[$];
    ev_t q_rd3[$], q_rv3[$], q_dn3[$];

    always #5 Clk1 = ~Clk1;
    always @(posedge Clk1) cyc <= cyc + 1;

    vec_mem_seq #(.RD_LAT(1)) dut1 (
        .Clk1(Clk1), .Reset(Reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_wr(req_wr), .req_base(req_base), .req_stride(req_stride), .req_cnt(req_cnt),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready1),
        .rdata(rdata1), .rdata_valid(rdata_valid1), .rdata_idx(rdata_idx1), .done(done1),
        .Addr(Addr1), .RD(RD1), .WR(WR1), .DataOut(DataOut1), .DataIn(DataIn1)
    );

    vec_mem_seq #(.RD_LAT(3)) dut3 (
        .Clk1(Clk1), .Reset(Reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_wr(req_wr), .req_base(req_base), .req_stride(req_stride), .req_cnt(req_cnt),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready3),
        .rdata(rdata3), .rdata_valid(rdata_valid3), .rdata_idx(rdata_idx3), .done(done3),
        .Addr(Addr3), .RD(RD3), .WR(WR3), .DataOut(DataOut3), .DataIn(DataIn3)
    );

    // Memory contents are mem[a] = a + 0x90; DataIn is junk unless the read
    // issued exactly RD_LAT cycles earlier is being returned.
    logic        m1_v;
    logic [15:0] m1_a;
    logic [2:0]  m3_v;
    logic [15:0] m3_a0, m3_a1, m3_a2;
    always @(posedge Clk1) begin
        m1_v  <= RD1;
        m1_a  <= Addr1;
        m3_v  <= {m3_v[1:0], RD3};
        m3_a0 <= Addr3;
        m3_a1 <= m3_a0;
        m3_a2 <= m3_a1;
    end
    assign DataIn1 = m1_v    ? m1_a  + 16'h0090 : 16'hDEAD;
    assign DataIn3 = m3_v[2] ? m3_a2 + 16'h0090 : 16'hDEAD;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(input int t, input logic [15:0] a, input logic [15:0] d,
                               input logic [1:0] i);
        ev_t e;
        e.cyc = t;
        e.a   = a;
        e.d   = d;
        e.idx = i;
        return e;
    endfunction

    function automatic logic [65:0] outs1();
        return {10'b0, req_ready1, wdata_ready1, rdata_valid1, rdata_idx1, done1, RD1, WR1,
                rdata1, Addr1, DataOut1};
    endfunction

    function automatic logic [65:0] outs3();
        return {10'b0, req_ready3, wdata_ready3, rdata_valid3, rdata_idx3, done3, RD3, WR3,
                rdata3, Addr3, DataOut3};
    endfunction

    // Expected load events for a request accepted in cycle t0; events at or
    // after cycle 'cut' are not expected (request abandoned by reset).
    task automatic exp_load(input bit which, input int t0, input logic [15:0] base,
                            input logic [15:0] stride, input int n, input int cut);
        int          lat;
        int          tr;
        logic [15:0] a;
        lat = which ? 3 : 1;
        for (int k = 0; k < n; k++) begin
            a  = base + 16'(k) * stride;
            tr = t0 + 1 + k * (lat + 1);
            if (tr < cut) begin
                if (which) q_rd3.push_back(mk(tr, a, 16'h0, 2'd0));
                else       q_rd1.push_back(mk(tr, a, 16'h0, 2'd0));
            end
            if (tr + lat + 1 < cut) begin
                if (which) q_rv3.push_back(mk(tr + lat + 1, 16'h0, a + 16'h0090, 2'(k)));
                else       q_rv1.push_back(mk(tr + lat + 1, 16'h0, a + 16'h0090, 2'(k)));
            end
        end
        if (t0 + n * (lat + 1) + 2 < cut) begin
            if (which) q_dn3.push_back(mk(t0 + n * (lat + 1) + 2, 16'h0, 16'h0, 2'd0));
            else       q_dn1.push_back(mk(t0 + n * (lat + 1) + 2, 16'h0, 16'h0, 2'd0));
        end
    endtask

    always @(negedge Clk1) begin
        ev_t e;
        chk("rd_wr_excl1", 66'(RD1 & WR1), 66'd0);
        chk("rd_wr_excl3", 66'(RD3 & WR3), 66'd0);
        if (RD1) begin
            if (q_rd1.size() != 0) e = q_rd1.pop_front(); else e = '1;
            chk("rd1", mk(cyc, Addr1, 16'h0, 2'd0), e);
        end
        if (rdata_valid1) begin
            if (q_rv1.size() != 0) e = q_rv1.pop_front(); else e = '1;
            chk("rvalid1", mk(cyc, 16'h0, rdata1, rdata_idx1), e);
        end
        if (WR1) begin
            if (q_wr1.size() != 0) e = q_wr1.pop_front(); else e = '1;
            chk("wr1", mk(cyc, Addr1, DataOut1, 2'd0), e);
        end
        if (done1) begin
            if (q_dn1.size() != 0) e = q_dn1.pop_front(); else e = '1;
            chk("done1", mk(cyc, 16'h0, 16'h0, 2'd0), e);
        end
        if (RD3) begin
            if (q_rd3.size() != 0) e = q_rd3.pop_front(); else e = '1;
            chk("rd3", mk(cyc, Addr3, 16'h0, 2'd0), e);
        end
        if (rdata_valid3) begin
            if (q_rv3.size() != 0) e = q_rv3.pop_front(); else e = '1;
            chk("rvalid3", mk(cyc, 16'h0, rdata3, rdata_idx3), e);
        end
        if (WR3) begin
            chk("wr3_unexpected", 66'(WR3), 66'd0);
        end
        if (done3) begin
            if (q_dn3.size() != 0) e = q_dn3.pop_front(); else e = '1;
            chk("done3", mk(cyc, 16'h0, 16'h0, 2'd0), e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk1);
        #1;
    endtask

    initial begin
        int t0;
        int t1;
        Reset       = 1'b0;
        req_valid1  = 1'b0;
        req_valid3  = 1'b0;
        req_wr      = 1'b0;
        req_base    = 16'h0;
        req_stride  = 16'h0;
        req_cnt     = 3'd0;
        wdata       = 16'h0;
        wdata_valid = 1'b0;
        tick(3);
        chk("reset_outs1", outs1(), {10'b0, 1'b1, 55'b0});
        chk("reset_outs3", outs3(), {10'b0, 1'b1, 55'b0});
        Reset = 1'b1;
        tick(2);

        // 4-element unit-stride load
        t0 = cyc;
        req_valid1 = 1'b1; req_wr = 1'b0; req_base = 16'h0010; req_stride = 16'h0001; req_cnt = 3'd4;
        exp_load(1'b0, t0, 16'h0010, 16'h0001, 4, 32'h7fffffff);
        tick(1);
        req_valid1 = 1'b0;
        tick(9);
        chk("ready_at_done1", 66'(req_ready1), 66'd0);
        tick(1);
        chk("ready_after_done1", 66'(req_ready1), 66'd1);
        tick(1);

        // store with address wrap, wdata_valid held high
        t0 = cyc;
        req_valid1 = 1'b1; req_wr = 1'b1; req_base = 16'hFFFE; req_stride = 16'h0001; req_cnt = 3'd3;
        wdata_valid = 1'b1; wdata = 16'h1111;
        q_wr1.push_back(mk(t0 + 2, 16'hFFFE, 16'h1111, 2'd0));
        q_wr1.push_back(mk(t0 + 4, 16'hFFFF, 16'h2222, 2'd0));
        q_wr1.push_back(mk(t0 + 6, 16'h0000, 16'h3333, 2'd0));
        q_dn1.push_back(mk(t0 + 7, 16'h0, 16'h0, 2'd0));
        tick(1);
        req_valid1 = 1'b0;
        tick(1);
        wdata = 16'h2222;
        tick(2);
        wdata = 16'h3333;
        tick(3);
        wdata_valid = 1'b0;
        tick(2);

        // store with a 5-cycle stall before element 1
        t0 = cyc;
        req_valid1 = 1'b1; req_wr = 1'b1; req_base = 16'h0200; req_stride = 16'h0004; req_cnt = 3'd2;
        wdata_valid = 1'b1; wdata = 16'hBEEF;
        q_wr1.push_back(mk(t0 + 2, 16'h0200, 16'hBEEF, 2'd0));
        q_wr1.push_back(mk(t0 + 9, 16'h0204, 16'hCAFE, 2'd0));
        q_dn1.push_back(mk(t0 + 10, 16'h0, 16'h0, 2'd0));
        tick(1);
        req_valid1 = 1'b0;
        tick(1);
        wdata_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_wdata_ready", 66'(wdata_ready1), 66'd1);
            chk("stall_wr", 66'(WR1), 66'd0);
        end
        tick(1);
        wdata_valid = 1'b1; wdata = 16'hCAFE;
        tick(1);
        wdata_valid = 1'b0;
        tick(3);

        // cnt = 0, then cnt = 7 (clamped to 4) with stride 0x100
        t0 = cyc;
        req_valid1 = 1'b1; req_wr = 1'b0; req_base = 16'h0777; req_stride = 16'h0001; req_cnt = 3'd0;
        q_dn1.push_back(mk(t0 + 1, 16'h0, 16'h0, 2'd0));
        tick(1);
        req_valid1 = 1'b0;
        chk("cnt0_busy", 66'(req_ready1), 66'd0);
        tick(1);
        t1 = cyc;
        req_valid1 = 1'b1; req_base = 16'h1234; req_stride = 16'h0100; req_cnt = 3'd7;
        exp_load(1'b0, t1, 16'h1234, 16'h0100, 4, 32'h7fffffff);
        tick(1);
        req_valid1 = 1'b0;
        tick(12);

        // reset during the third RD_WAIT
        t0 = cyc;
        req_valid1 = 1'b1; req_base = 16'h0040; req_stride = 16'h0002; req_cnt = 3'd4;
        exp_load(1'b0, t0, 16'h0040, 16'h0002, 4, t0 + 6);
        tick(1);
        req_valid1 = 1'b0;
        tick(5);
        Reset = 1'b0;
        #1;
        chk("midrun_reset_outs1", outs1(), {10'b0, 1'b1, 55'b0});
        tick(2);
        Reset = 1'b1;
        tick(1);
        t0 = cyc;
        req_valid1 = 1'b1; req_base = 16'h0050; req_stride = 16'h0001; req_cnt = 3'd2;
        exp_load(1'b0, t0, 16'h0050, 16'h0001, 2, 32'h7fffffff);
        tick(1);
        req_valid1 = 1'b0;
        tick(8);

        // RD_LAT = 3, req_valid held high across two requests
        t0 = cyc;
        req_valid3 = 1'b1; req_wr = 1'b0; req_base = 16'h0300; req_stride = 16'h0010; req_cnt = 3'd2;
        exp_load(1'b1, t0, 16'h0300, 16'h0010, 2, 32'h7fffffff);
        exp_load(1'b1, t0 + 11, 16'h0300, 16'h0010, 2, 32'h7fffffff);
        tick(1);
        chk("lat3_busy_ready", 66'(req_ready3), 66'd0);
        tick(9);
        chk("lat3_ready_at_done", 66'(req_ready3), 66'd0);
        tick(1);
        chk("lat3_ready_after_done", 66'(req_ready3), 66'd1);
        tick(1);
        req_valid3 = 1'b0;
        tick(12);

        chk("scoreboard_drained",
            66'(q_rd1.size() + q_rv1.size() + q_wr1.size() + q_dn1.size()
                + q_rd3.size() + q_rv3.size() + q_dn3.size()), 66'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
